// File: rtl/feature_map_source.sv
// rtl/feature_map_source.sv - streams one stored feature map in raster order from a sync-read buffer
// Reads are credit-limited against a 2-entry output queue so backpressure never drops data.
module feature_map_source #(
  parameter int FEATURE_WIDTH = 16,
  parameter int FEATURE_DEPTH = 6,
  parameter int MAP_ROWS      = 28,
  parameter int MAP_COLS      = 28,
  parameter int ADDR_WIDTH    = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_rd_en,
  output logic [ADDR_WIDTH-1:0]    mem_rd_addr,
  input  logic [FEATURE_WIDTH-1:0] mem_rd_data [FEATURE_DEPTH],
  output logic                     features_valid,
  input  logic                     features_ready,
  output logic [FEATURE_WIDTH-1:0] features_out [FEATURE_DEPTH],
  output logic                     col_last,
  output logic                     frame_last
);

  localparam int ROW_W = (MAP_ROWS > 1) ? $clog2(MAP_ROWS) : 1;
  localparam int COL_W = (MAP_COLS > 1) ? $clog2(MAP_COLS) : 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAP_ROWS * MAP_COLS - 1);
  localparam logic [ROW_W-1:0]      LAST_ROW  = ROW_W'(MAP_ROWS - 1);
  localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(MAP_COLS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  state_t state;

  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col;

  // One read in flight at most: data returns the cycle after the strobe is sampled.
  logic pend;
  logic pend_col_last;
  logic pend_frame_last;

  logic [1:0]               q_count;
  logic [FEATURE_WIDTH-1:0] head_data [FEATURE_DEPTH];
  logic [FEATURE_WIDTH-1:0] tail_data [FEATURE_DEPTH];
  logic                     head_col_last;
  logic                     head_frame_last;
  logic                     tail_col_last;
  logic                     tail_frame_last;

  logic       pop;
  logic       issue_col_last;
  logic       issue_frame_last;
  logic [2:0] credit_used;

  assign features_valid = (q_count != 2'd0);
  assign pop            = features_valid && features_ready;
  assign col_last       = features_valid && head_col_last;
  assign frame_last     = features_valid && head_frame_last;
  assign features_out   = head_data;

  assign issue_col_last   = (rd_col == LAST_COL);
  assign issue_frame_last = issue_col_last && (rd_row == LAST_ROW);

  // Counting this cycle's pop as freed space keeps full throughput with only two entries.
  assign credit_used = {1'b0, q_count} + {2'b00, pend} - {2'b00, pop};
  assign mem_rd_en   = (state == STREAM) && (credit_used < 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      busy            <= 1'b0;
      done            <= 1'b0;
      mem_rd_addr     <= '0;
      rd_row          <= '0;
      rd_col          <= '0;
      pend            <= 1'b0;
      pend_col_last   <= 1'b0;
      pend_frame_last <= 1'b0;
    end else begin
      done            <= 1'b0;
      pend            <= mem_rd_en;
      pend_col_last   <= mem_rd_en && issue_col_last;
      pend_frame_last <= mem_rd_en && issue_frame_last;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= STREAM;
            busy        <= 1'b1;
            mem_rd_addr <= '0;
            rd_row      <= '0;
            rd_col      <= '0;
          end
        end
        STREAM: begin
          if (mem_rd_en) begin
            if (mem_rd_addr == LAST_ADDR) begin
              state       <= DRAIN;
              mem_rd_addr <= '0;
            end else begin
              mem_rd_addr <= mem_rd_addr + ADDR_WIDTH'(1);
            end
            if (issue_col_last) begin
              rd_col <= '0;
              rd_row <= rd_row + ROW_W'(1);
            end else begin
              rd_col <= rd_col + COL_W'(1);
            end
          end
        end
        DRAIN: begin
          if (pop && head_frame_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Head keeps its payload after the queue empties; only the flags are gated by valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_count         <= 2'd0;
      head_col_last   <= 1'b0;
      head_frame_last <= 1'b0;
      tail_col_last   <= 1'b0;
      tail_frame_last <= 1'b0;
      for (int i = 0; i < FEATURE_DEPTH; i++) begin
        head_data[i] <= '0;
        tail_data[i] <= '0;
      end
    end else begin
      q_count <= q_count + {1'b0, pend} - {1'b0, pop};
      if (pend && ((q_count == 2'd0) || ((q_count == 2'd1) && pop))) begin
        head_data       <= mem_rd_data;
        head_col_last   <= pend_col_last;
        head_frame_last <= pend_frame_last;
      end else if (pop && (q_count == 2'd2)) begin
        head_data       <= tail_data;
        head_col_last   <= tail_col_last;
        head_frame_last <= tail_frame_last;
      end
      if (pend && (((q_count == 2'd1) && !pop) || (q_count == 2'd2))) begin
        tail_data       <= mem_rd_data;
        tail_col_last   <= pend_col_last;
        tail_frame_last <= pend_frame_last;
      end
    end
  end

endmodule

// File: tb/tb_feature_map_source.sv
// tb/tb_feature_map_source.sv - directed table-driven bench for feature_map_source
// Checks a 3x4 map (backpressure, stalls, ignored starts, mid-frame reset) and a 1x1 map back-to-back.
module tb_feature_map_source;

  localparam int FW   = 16;
  localparam int FD   = 6;
  localparam int ROWS = 3;
  localparam int COLS = 4;
  localparam int AW   = 4;
  localparam int NPIX = ROWS * COLS;

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          start, busy, done, mem_rd_en, features_valid, features_ready, col_last, frame_last;
  logic [AW-1:0] mem_rd_addr;
  logic [FW-1:0] mem_rd_data [FD];
  logic [FW-1:0] features_out [FD];

  logic          start1, busy1, done1, mem_rd_en1, features_valid1, features_ready1, col_last1, frame_last1;
  logic [0:0]    mem_rd_addr1;
  logic [FW-1:0] mem_rd_data1 [FD];
  logic [FW-1:0] features_out1 [FD];

  feature_map_source #(
    .FEATURE_WIDTH(FW), .FEATURE_DEPTH(FD), .MAP_ROWS(ROWS), .MAP_COLS(COLS), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .features_valid(features_valid), .features_ready(features_ready), .features_out(features_out),
    .col_last(col_last), .frame_last(frame_last)
  );

  feature_map_source #(
    .FEATURE_WIDTH(FW), .FEATURE_DEPTH(FD), .MAP_ROWS(1), .MAP_COLS(1), .ADDR_WIDTH(1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .mem_rd_en(mem_rd_en1), .mem_rd_addr(mem_rd_addr1), .mem_rd_data(mem_rd_data1),
    .features_valid(features_valid1), .features_ready(features_ready1), .features_out(features_out1),
    .col_last(col_last1), .frame_last(frame_last1)
  );

  // Buffer word k holds {k, k+1, ..., k+5}.
  always @(posedge clk) begin
    if (mem_rd_en) for (int i = 0; i < FD; i++) mem_rd_data[i] <= FW'(int'(mem_rd_addr) + i);
    if (mem_rd_en1) for (int i = 0; i < FD; i++) mem_rd_data1[i] <= FW'(int'(mem_rd_addr1) + i);
  end

  int cyc = 0;
  int f_beats = 0, f_reads = 0, f_max_out = 0;
  int f_start_cyc = 0, f_first_cyc = 0, f_last_cyc = 0;
  int dones = 0, last_done_cyc = 0;
  int bad_addr = 0, bad_beat = 0, bad_hold = 0, bad_flag = 0;
  logic stalled = 1'b0;
  logic held_cl, held_fl;
  logic [FW-1:0] held [FD];
  int beats1 = 0, dones1 = 0, bad1 = 0;
  int beat1_cyc [2];
  int done1_cyc [2];

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      f_beats = 0; f_reads = 0; f_max_out = 0; stalled = 1'b0;
    end else begin
      if (start && !busy) begin
        f_beats = 0; f_reads = 0; f_max_out = 0; f_start_cyc = cyc;
      end
      if (mem_rd_en) begin
        if (int'(mem_rd_addr) != f_reads) bad_addr++;
        f_reads++;
      end
      if (stalled) begin
        if (!features_valid || col_last !== held_cl || frame_last !== held_fl) bad_hold++;
        for (int i = 0; i < FD; i++) if (features_out[i] !== held[i]) bad_hold++;
      end
      if (!features_valid && (col_last || frame_last)) bad_flag++;
      if (features_valid && features_ready) begin
        for (int i = 0; i < FD; i++) if (features_out[i] !== FW'(f_beats + i)) bad_beat++;
        if (col_last !== (f_beats % COLS == COLS - 1)) bad_beat++;
        if (frame_last !== (f_beats == NPIX - 1)) bad_beat++;
        if (f_beats == 0) f_first_cyc = cyc;
        f_last_cyc = cyc;
        f_beats++;
      end
      stalled = features_valid && !features_ready;
      held = features_out;
      held_cl = col_last;
      held_fl = frame_last;
      if (done) begin dones++; last_done_cyc = cyc; end
      if (f_reads - f_beats > f_max_out) f_max_out = f_reads - f_beats;

      if (features_valid1 && features_ready1) begin
        if (!col_last1 || !frame_last1 || features_out1[0] !== 16'd0 || features_out1[5] !== 16'd5) bad1++;
        if (beats1 < 2) beat1_cyc[beats1] = cyc;
        beats1++;
      end
      if (done1) begin
        if (dones1 < 2) done1_cyc[dones1] = cyc;
        dones1++;
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int nz_a();
    int n = 0;
    n = int'(busy) + int'(done) + int'(mem_rd_en) + int'(features_valid) + int'(col_last) + int'(frame_last);
    if (mem_rd_addr != '0) n++;
    for (int i = 0; i < FD; i++) if (features_out[i] != '0) n++;
    return n;
  endfunction

  typedef struct {
    logic [3:0] ready_pat;
    int hold_cycles;
    int restart_a;
    int restart_b;
    int exp_beats;
    int exp_latency;
    int exp_span;
  } vec_t;

  vec_t vecs [4];

  task automatic run_vec(input vec_t v);
    int d0, ba, bb, bh, bf, n, ph;
    bit rs_a, rs_b, seen_done;
    d0 = dones; ba = bad_addr; bb = bad_beat; bh = bad_hold; bf = bad_flag;
    features_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0; ph = 0; rs_a = 0; rs_b = 0; seen_done = 0;
    while (!seen_done && n < 300) begin
      if (n < v.hold_cycles) features_ready = 1'b0;
      else begin
        features_ready = v.ready_pat[ph];
        ph = (ph + 1) % 4;
      end
      if (start) start = 1'b0;
      else if (!rs_a && v.restart_a >= 0 && f_beats == v.restart_a) begin start = 1'b1; rs_a = 1; end
      else if (!rs_b && v.restart_b >= 0 && f_beats == v.restart_b) begin start = 1'b1; rs_b = 1; end
      @(posedge clk); #1;
      n++;
      if (done) seen_done = 1;
      if (v.hold_cycles > 0 && n == v.hold_cycles) begin
        check("hold_reads", f_reads, 2);
        check("hold_valid", int'(features_valid), 1);
        check("hold_beat0", int'(features_out[0]), 0);
      end
    end
    start = 1'b0;
    features_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("beats", f_beats, v.exp_beats);
    check("dones", dones - d0, 1);
    check("addr_order", bad_addr - ba, 0);
    check("payload", bad_beat - bb, 0);
    check("stall_hold", bad_hold - bh, 0);
    check("idle_flags", bad_flag - bf, 0);
    check("outstanding_le2", int'(f_max_out <= 2), 1);
    if (v.exp_latency >= 0) check("first_latency", f_first_cyc - f_start_cyc, v.exp_latency);
    if (v.exp_span >= 0) check("beat_span", f_last_cyc - f_first_cyc, v.exp_span);
    check("done_after_last", last_done_cyc - f_last_cyc, 1);
    check("busy_end", int'(busy), 0);
  endtask

  initial begin
    int n, d0;
    vecs[0] = '{4'b1111, 0, -1, -1, 12, 3, 11};
    vecs[1] = '{4'b1001, 0, -1, -1, 12, -1, -1};
    vecs[2] = '{4'b1111, 20, -1, -1, 12, -1, -1};
    vecs[3] = '{4'b1111, 0, 5, 9, 12, 3, 11};

    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; features_ready = 1'b1; features_ready1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", nz_a(), 0);
    check("reset_outputs_1x1", int'(busy1) + int'(features_valid1) + int'(mem_rd_en1), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int k = 0; k < 4; k++) run_vec(vecs[k]);

    // Mid-frame reset after beat 6.
    features_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (f_beats < 6 && n < 100) begin @(posedge clk); #1; n++; end
    check("rst_reach_beat6", f_beats, 6);
    d0 = dones;
    rst_n = 1'b0;
    #1;
    check("rst_async_zero", nz_a(), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_no_beats", f_beats, 0);
    check("rst_idle_valid", int'(features_valid), 0);
    check("rst_idle_busy", int'(busy), 0);
    check("rst_no_done", dones - d0, 0);
    run_vec(vecs[0]);

    // 1x1 map, second start in the done cycle.
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    n = 0;
    while (!done1 && n < 50) begin @(posedge clk); #1; n++; end
    start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    n = 0;
    while (dones1 < 2 && n < 50) begin @(posedge clk); #1; n++; end
    repeat (3) @(posedge clk);
    #1;
    check("one_beats", beats1, 2);
    check("one_dones", dones1, 2);
    check("one_flags_payload", bad1, 0);
    check("one_done_after_beat", done1_cyc[0] - beat1_cyc[0], 1);
    check("one_b2b_latency", beat1_cyc[1] - done1_cyc[0], 3);
    check("one_busy_end", int'(busy1), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
